// File: rtl/vending_machine_param.sv
// Card-operated vending FSM: two-digit key entry, per-slot stock counters, payment wait, vend.
// Latency: all outputs decode the state register, so they follow the causing input by one cycle.
// No backpressure: inputs are sampled every cycle; wait counters bound each key and payment wait.
module vending_machine_param #(
    parameter int ROWS         = 2,
    parameter int COLS         = 5,
    parameter int STOCK_W      = 4,
    parameter int STOCK_MAX    = 10,
    parameter int KEY_TIMEOUT  = 5,
    parameter int TRAN_TIMEOUT = 5,
    parameter int COST_W       = 3,
    parameter logic [ROWS*COST_W-1:0] COST_TABLE = {3'd5, 3'd2}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RELOAD,
    input  logic              CARD_IN,
    input  logic [2:0]        ITEM_CODE,
    input  logic              KEY_PRESS,
    input  logic              VALID_TRAN,
    input  logic              CANCEL,
    output logic              VEND,
    output logic              INVALID_SEL,
    output logic              SOLD_OUT,
    output logic [COST_W-1:0] COST,
    output logic              FAILED_TRAN,
    output logic              BUSY
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_LOAD     = 4'd2;
    localparam logic [3:0] S_KEY1     = 4'd3;
    localparam logic [3:0] S_KEY2     = 4'd4;
    localparam logic [3:0] S_CHECK    = 4'd5;
    localparam logic [3:0] S_TRANSACT = 4'd6;
    localparam logic [3:0] S_VEND     = 4'd7;
    localparam logic [3:0] S_INVALID  = 4'd8;
    localparam logic [3:0] S_SOLDOUT  = 4'd9;
    localparam logic [3:0] S_FAILED   = 4'd10;

    localparam int TMAX  = (KEY_TIMEOUT > TRAN_TIMEOUT) ? KEY_TIMEOUT : TRAN_TIMEOUT;
    localparam int CNT_W = $clog2(TMAX + 1);

    logic [3:0]         state_q;
    logic [3:0]         state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2:0]         row_q;
    logic [2:0]         col_q;
    logic [STOCK_W-1:0] stock [ROWS][COLS];
    logic [STOCK_W-1:0] slot_stock;
    logic [COST_W-1:0]  cost_sel;
    logic               code_bad;
    logic               key_to;
    logic               tran_to;

    // Widened by one bit so COLS = 8 still compares correctly against a 3-bit digit.
    assign code_bad = (row_q == 3'd0) || ({1'b0, row_q} > 4'(ROWS)) || ({1'b0, col_q} >= 4'(COLS));
    assign key_to   = (wait_cnt == CNT_W'(KEY_TIMEOUT - 1));
    assign tran_to  = (wait_cnt == CNT_W'(TRAN_TIMEOUT - 1));

    always_comb begin
        slot_stock = '0;
        cost_sel   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == 3'(r + 1)) begin
                cost_sel = COST_TABLE[r*COST_W +: COST_W];
            end
            for (int c = 0; c < COLS; c++) begin
                if (row_q == 3'(r + 1) && col_q == 3'(c)) begin
                    slot_stock = stock[r][c];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_RST:  state_nxt = S_IDLE;
            S_IDLE: begin
                if (RELOAD)       state_nxt = S_LOAD;
                else if (CARD_IN) state_nxt = S_KEY1;
            end
            S_LOAD: state_nxt = S_IDLE;
            S_KEY1: begin
                if (CANCEL)         state_nxt = S_IDLE;
                else if (KEY_PRESS) state_nxt = S_KEY2;
                else if (key_to)    state_nxt = S_IDLE;
            end
            S_KEY2: begin
                if (CANCEL)         state_nxt = S_IDLE;
                else if (KEY_PRESS) state_nxt = S_CHECK;
                else if (key_to)    state_nxt = S_IDLE;
            end
            S_CHECK: begin
                if (code_bad)              state_nxt = S_INVALID;
                else if (slot_stock == '0) state_nxt = S_SOLDOUT;
                else                       state_nxt = S_TRANSACT;
            end
            S_TRANSACT: begin
                if (CANCEL)          state_nxt = S_IDLE;
                else if (VALID_TRAN) state_nxt = S_VEND;
                else if (tran_to)    state_nxt = S_FAILED;
            end
            S_VEND, S_INVALID, S_SOLDOUT, S_FAILED: state_nxt = S_IDLE;
            default: state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_RST;
            wait_cnt <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q <= state_nxt;
            // Cleared on every state change so each waiting state starts counting from zero.
            if (state_nxt != state_q) begin
                wait_cnt <= '0;
            end else if (state_q == S_KEY1 || state_q == S_KEY2 || state_q == S_TRANSACT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state_q == S_KEY1 && !CANCEL && KEY_PRESS) row_q <= ITEM_CODE;
            if (state_q == S_KEY2 && !CANCEL && KEY_PRESS) col_q <= ITEM_CODE;
        end
    end

    always_ff @(posedge CLK) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (RESET) begin
                    stock[r][c] <= '0;
                end else if (state_q == S_LOAD) begin
                    stock[r][c] <= STOCK_W'(STOCK_MAX);
                end else if (state_q == S_VEND && row_q == 3'(r + 1) && col_q == 3'(c)
                             && stock[r][c] != '0) begin
                    stock[r][c] <= stock[r][c] - STOCK_W'(1);
                end
            end
        end
    end

    assign VEND        = (state_q == S_VEND);
    assign INVALID_SEL = (state_q == S_INVALID);
    assign SOLD_OUT    = (state_q == S_SOLDOUT);
    assign FAILED_TRAN = (state_q == S_FAILED);
    assign COST        = (state_q == S_TRANSACT) ? cost_sel : '0;
    assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param at default parameters.
module tb_vending_machine_param;

    logic       CLK = 1'b0;
    logic       RESET, RELOAD, CARD_IN, KEY_PRESS, VALID_TRAN, CANCEL;
    logic [2:0] ITEM_CODE;
    logic       VEND, INVALID_SEL, SOLD_OUT, FAILED_TRAN, BUSY;
    logic [2:0] COST;

    int checks = 0;
    int passed = 0;

    vending_machine_param dut (
        .CLK(CLK), .RESET(RESET), .RELOAD(RELOAD), .CARD_IN(CARD_IN),
        .ITEM_CODE(ITEM_CODE), .KEY_PRESS(KEY_PRESS), .VALID_TRAN(VALID_TRAN),
        .CANCEL(CANCEL), .VEND(VEND), .INVALID_SEL(INVALID_SEL), .SOLD_OUT(SOLD_OUT),
        .COST(COST), .FAILED_TRAN(FAILED_TRAN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [2:0] code);
        ITEM_CODE = code;
        KEY_PRESS = 1'b1;
        tick();
        KEY_PRESS = 1'b0;
    endtask

    // Card in, two digits; returns with the FSM in CHECK.
    task automatic start_session(input logic [2:0] r, input logic [2:0] c);
        CARD_IN = 1'b1;
        tick();
        CARD_IN = 1'b0;
        press(r);
        press(c);
    endtask

    task automatic test_reset();
        int nz;
        RESET = 1'b1;
        tick();
        checks++;
        if ({VEND, INVALID_SEL, SOLD_OUT, FAILED_TRAN, COST} !== 7'd0 || BUSY !== 1'b1)
            $display("FAIL reset_rst outs=%b busy=%b want outs=0 busy=1",
                     {VEND, INVALID_SEL, SOLD_OUT, FAILED_TRAN, COST}, BUSY);
        else passed++;
        RESET = 1'b0;
        tick();
        checks++;
        if (BUSY !== 1'b0) $display("FAIL reset_idle busy=%b want 0", BUSY);
        else passed++;
        nz = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++)
                if (dut.stock[r][c] !== 4'd0) nz++;
        checks++;
        if (nz !== 0) $display("FAIL reset_stock nonzero_slots=%0d want 0", nz);
        else passed++;
    endtask

    task automatic test_sold_out();
        CARD_IN = 1'b1;
        tick();
        CARD_IN = 1'b0;
        press(3'd2);
        RELOAD = 1'b1;
        press(3'd0);
        RELOAD = 1'b0;
        tick();
        checks++;
        if (SOLD_OUT !== 1'b1 || VEND !== 1'b0 || INVALID_SEL !== 1'b0)
            $display("FAIL sold_out sold=%b vend=%b inv=%b want 1 0 0", SOLD_OUT, VEND, INVALID_SEL);
        else passed++;
        tick();
        checks++;
        if (SOLD_OUT !== 1'b0 || BUSY !== 1'b0 || dut.stock[1][0] !== 4'd0)
            $display("FAIL sold_out_after sold=%b busy=%b stock=%0d want 0 0 0",
                     SOLD_OUT, BUSY, dut.stock[1][0]);
        else passed++;
    endtask

    task automatic test_reload_priority();
        int bad;
        RELOAD  = 1'b1;
        CARD_IN = 1'b1;
        tick();
        RELOAD  = 1'b0;
        CARD_IN = 1'b0;
        checks++;
        if (BUSY !== 1'b1) $display("FAIL reload_load busy=%b want 1", BUSY);
        else passed++;
        tick();
        checks++;
        if (BUSY !== 1'b0) $display("FAIL reload_no_session busy=%b want 0", BUSY);
        else passed++;
        bad = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++)
                if (dut.stock[r][c] !== 4'd10) bad++;
        checks++;
        if (bad !== 0) $display("FAIL reload_stock slots_not_10=%0d want 0", bad);
        else passed++;
    endtask

    task automatic test_vend();
        start_session(3'd1, 3'd2);
        checks++;
        if (COST !== 3'd0 || BUSY !== 1'b1) $display("FAIL vend_check cost=%0d busy=%b want 0 1", COST, BUSY);
        else passed++;
        tick();
        checks++;
        if (COST !== 3'd2 || VEND !== 1'b0) $display("FAIL vend_tran1 cost=%0d vend=%b want 2 0", COST, VEND);
        else passed++;
        tick();
        checks++;
        if (COST !== 3'd2) $display("FAIL vend_tran2 cost=%0d want 2", COST);
        else passed++;
        VALID_TRAN = 1'b1;
        tick();
        VALID_TRAN = 1'b0;
        checks++;
        if (VEND !== 1'b1 || COST !== 3'd0) $display("FAIL vend_pulse vend=%b cost=%0d want 1 0", VEND, COST);
        else passed++;
        tick();
        checks++;
        if (VEND !== 1'b0 || BUSY !== 1'b0) $display("FAIL vend_single vend=%b busy=%b want 0 0", VEND, BUSY);
        else passed++;
        checks++;
        if (dut.stock[0][2] !== 4'd9 || dut.stock[0][1] !== 4'd10)
            $display("FAIL vend_stock s12=%0d s11=%0d want 9 10", dut.stock[0][2], dut.stock[0][1]);
        else passed++;
    endtask

    task automatic test_invalid();
        logic [2:0] rows [4] = '{3'd3, 3'd1, 3'd0, 3'd1};
        logic [2:0] cols [4] = '{3'd0, 3'd7, 3'd1, 3'd5};
        for (int i = 0; i < 4; i++) begin
            start_session(rows[i], cols[i]);
            tick();
            checks++;
            if (INVALID_SEL !== 1'b1 || SOLD_OUT !== 1'b0 || COST !== 3'd0)
                $display("FAIL invalid_%0d%0d inv=%b sold=%b cost=%0d want 1 0 0",
                         rows[i], cols[i], INVALID_SEL, SOLD_OUT, COST);
            else passed++;
            tick();
            checks++;
            if (INVALID_SEL !== 1'b0 || BUSY !== 1'b0)
                $display("FAIL invalid_end_%0d%0d inv=%b busy=%b want 0 0", rows[i], cols[i], INVALID_SEL, BUSY);
            else passed++;
        end
    endtask

    task automatic test_key_timeout();
        int n;
        logic pulses;
        CARD_IN = 1'b1;
        tick();
        CARD_IN = 1'b0;
        n = 0;
        pulses = 1'b0;
        for (int i = 0; i < 12 && BUSY === 1'b1; i++) begin
            n++;
            pulses = pulses | VEND | INVALID_SEL | SOLD_OUT | FAILED_TRAN;
            tick();
        end
        checks++;
        if (n !== 5 || pulses !== 1'b0)
            $display("FAIL key1_timeout cycles=%0d pulses=%b want 5 0", n, pulses);
        else passed++;
        // Key on the final KEY1 cycle must still be accepted.
        CARD_IN = 1'b1;
        tick();
        CARD_IN = 1'b0;
        repeat (4) tick();
        press(3'd1);
        checks++;
        if (BUSY !== 1'b1) $display("FAIL key1_last_cycle busy=%b want 1", BUSY);
        else passed++;
        n = 0;
        for (int i = 0; i < 12 && BUSY === 1'b1; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 5) $display("FAIL key2_timeout cycles=%0d want 5", n);
        else passed++;
    endtask

    task automatic test_tran_timeout();
        int n;
        start_session(3'd2, 3'd4);
        tick();
        n = 0;
        for (int i = 0; i < 12 && COST === 3'd5; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 5) $display("FAIL tran_timeout cost5_cycles=%0d want 5", n);
        else passed++;
        checks++;
        if (FAILED_TRAN !== 1'b1 || VEND !== 1'b0) $display("FAIL failed_pulse failed=%b vend=%b want 1 0", FAILED_TRAN, VEND);
        else passed++;
        tick();
        checks++;
        if (FAILED_TRAN !== 1'b0 || BUSY !== 1'b0 || dut.stock[1][4] !== 4'd10)
            $display("FAIL failed_after failed=%b busy=%b stock=%0d want 0 0 10", FAILED_TRAN, BUSY, dut.stock[1][4]);
        else passed++;
    endtask

    task automatic test_cancel();
        start_session(3'd1, 3'd2);
        tick();
        CANCEL     = 1'b1;
        VALID_TRAN = 1'b1;
        tick();
        CANCEL     = 1'b0;
        VALID_TRAN = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || VEND !== 1'b0) $display("FAIL cancel busy=%b vend=%b want 0 0", BUSY, VEND);
        else passed++;
        tick();
        checks++;
        if (VEND !== 1'b0 || dut.stock[0][2] !== 4'd9)
            $display("FAIL cancel_stock vend=%b stock=%0d want 0 9", VEND, dut.stock[0][2]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int vends;
        vends = 0;
        for (int k = 0; k < 2; k++) begin
            start_session(3'd2, 3'd1);
            tick();
            VALID_TRAN = 1'b1;
            tick();
            VALID_TRAN = 1'b0;
            if (VEND === 1'b1) vends++;
            tick();
        end
        checks++;
        if (vends !== 2 || dut.stock[1][1] !== 4'd8)
            $display("FAIL back_to_back vends=%0d stock=%0d want 2 8", vends, dut.stock[1][1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int nz;
        start_session(3'd1, 3'd2);
        tick();
        checks++;
        if (COST !== 3'd2) $display("FAIL rst_mid_pre cost=%0d want 2", COST);
        else passed++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if (COST !== 3'd0 || BUSY !== 1'b1) $display("FAIL rst_mid_rst cost=%0d busy=%b want 0 1", COST, BUSY);
        else passed++;
        tick();
        checks++;
        if (BUSY !== 1'b0) $display("FAIL rst_mid_idle busy=%b want 0", BUSY);
        else passed++;
        nz = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 5; c++)
                if (dut.stock[r][c] !== 4'd0) nz++;
        checks++;
        if (nz !== 0) $display("FAIL rst_mid_stock nonzero_slots=%0d want 0", nz);
        else passed++;
    endtask

    initial begin
        RESET      = 1'b0;
        RELOAD     = 1'b0;
        CARD_IN    = 1'b0;
        KEY_PRESS  = 1'b0;
        VALID_TRAN = 1'b0;
        CANCEL     = 1'b0;
        ITEM_CODE  = 3'd0;
        test_reset();
        test_sold_out();
        test_reload_priority();
        test_vend();
        test_invalid();
        test_key_timeout();
        test_tran_timeout();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
